// File: rtl/btn_press_classifier_if.sv
// -----------------------------------------------------------------------------
// btn_press_classifier_if
//   Groups the debounced button level and the classified press events for one
//   button. The classifier drives the events; the consumer (stopwatch control
//   FSM or a testbench) drives the button level.
//
//   Signals:
//     i_btn    debounced button level, 1 = pressed
//     o_short  one-cycle pulse: press released before the long threshold
//     o_long   one-cycle pulse: long threshold reached (and each auto-repeat)
//     o_held   level: button is in the long-held state
//
//   Modports:
//     master  drives i_btn, observes the events
//     slave   the classifier side
// -----------------------------------------------------------------------------
interface btn_press_classifier_if;
    logic i_btn;
    logic o_short;
    logic o_long;
    logic o_held;

    modport master (
        output i_btn,
        input  o_short,
        input  o_long,
        input  o_held
    );

    modport slave (
        input  i_btn,
        output o_short,
        output o_long,
        output o_held
    );
endinterface

// File: rtl/btn_press_classifier.sv
// -----------------------------------------------------------------------------
// btn_press_classifier
//   Turns a debounced button level into single-cycle press events for the
//   stopwatch control FSM. A press released before LONG_CYCLES is a short press
//   (o_short pulse on release); a press held past LONG_CYCLES gives an o_long
//   pulse and o_held stays high until release, which is silent. All outputs are
//   registered.
//
//   Optional feature, macro BTN_AUTO_REPEAT_EN: while long-held, o_long repeats
//   every REPEAT_CYCLES cycles. Without the macro the repeat counter does not
//   exist and exactly one o_long is produced per press.
//
//   Parameters:
//     LONG_CYCLES    cycles of continuous press classified as long (>= 2)
//     REPEAT_CYCLES  auto-repeat period while long-held (>= 1, macro builds)
//
//   Ports:
//     clk     system clock, rising edge
//     reset   synchronous, active-high reset
//     io_bus  btn_press_classifier_if.slave: i_btn in; o_short/o_long/o_held out
// -----------------------------------------------------------------------------
module btn_press_classifier #(
    parameter int unsigned LONG_CYCLES   = 100_000_000,
    parameter int unsigned REPEAT_CYCLES = 20_000_000
) (
    input  logic                         clk,
    input  logic                         reset,
    btn_press_classifier_if.slave        io_bus
);

    localparam int unsigned CntW = $clog2(LONG_CYCLES + 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [CntW-1:0] CntLong = CntW'(LONG_CYCLES);

    // Reject illegal configurations at elaboration.
    if ((LONG_CYCLES < 2) || (REPEAT_CYCLES < 1)) begin : g_bad_params
        $error("btn_press_classifier: LONG_CYCLES must be >= 2, REPEAT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        StIdle,
        StPressed,
        StLongHeld
    } state_e;

    state_e          r_state;
    state_e          w_state_nxt;
    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_nxt;
    logic            r_btn;
    logic            r_short;
    logic            w_short_nxt;
    logic            r_long;
    logic            w_long_nxt;
    logic            r_held;
    logic            w_held_nxt;

`ifdef BTN_AUTO_REPEAT_EN
    localparam int unsigned RcntW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RcntW-1:0] RcntOne  = RcntW'(1);
    localparam logic [RcntW-1:0] RcntLast = RcntW'(REPEAT_CYCLES - 1);

    logic [RcntW-1:0] r_rcnt;
    logic [RcntW-1:0] w_rcnt_nxt;
`endif

    // Next-state and output decode. The FSM only ever looks at the registered
    // button level r_btn.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_short_nxt = 1'b0;
        w_long_nxt  = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
        w_rcnt_nxt  = r_rcnt;
`endif

        unique case (r_state)
            StIdle: begin
                if (r_btn) begin
                    w_state_nxt = StPressed;
                    w_cnt_nxt   = CntOne;
                end
            end

            StPressed: begin
                if (!r_btn) begin
                    w_state_nxt = StIdle;
                    w_cnt_nxt   = '0;
                    w_short_nxt = 1'b1;
                end else if (r_cnt == CntLong) begin
                    w_state_nxt = StLongHeld;
                    w_long_nxt  = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
                    w_rcnt_nxt  = '0;
`endif
                end else begin
                    // Saturates at CntLong because the branch above leaves.
                    w_cnt_nxt = r_cnt + CntOne;
                end
            end

            StLongHeld: begin
                if (!r_btn) begin
                    // Release after a long press is silent.
                    w_state_nxt = StIdle;
                    w_cnt_nxt   = '0;
`ifdef BTN_AUTO_REPEAT_EN
                    w_rcnt_nxt  = '0;
`endif
                end else begin
`ifdef BTN_AUTO_REPEAT_EN
                    if (r_rcnt == RcntLast) begin
                        w_long_nxt = 1'b1;
                        w_rcnt_nxt = '0;
                    end else begin
                        w_rcnt_nxt = r_rcnt + RcntOne;
                    end
`endif
                end
            end

            default: begin
                w_state_nxt = StIdle;
                w_cnt_nxt   = '0;
            end
        endcase

        w_held_nxt = (w_state_nxt == StLongHeld);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_btn   <= 1'b0;
            r_short <= 1'b0;
            r_long  <= 1'b0;
            r_held  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_btn   <= io_bus.i_btn;
            r_short <= w_short_nxt;
            r_long  <= w_long_nxt;
            r_held  <= w_held_nxt;
        end
    end

`ifdef BTN_AUTO_REPEAT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rcnt <= '0;
        end else begin
            r_rcnt <= w_rcnt_nxt;
        end
    end
`endif

    assign io_bus.o_short = r_short;
    assign io_bus.o_long  = r_long;
    assign io_bus.o_held  = r_held;

endmodule

// File: tb/tb_btn_press_classifier.sv
// -----------------------------------------------------------------------------
// tb_btn_press_classifier
//   Self-checking bench for btn_press_classifier with LONG_CYCLES=20,
//   REPEAT_CYCLES=5 and a 10 ns clock. Works with or without
//   BTN_AUTO_REPEAT_EN defined. Every cycle the outputs are compared with a
//   reference model that reasons only about lengths of runs of sampled 1s.
// -----------------------------------------------------------------------------
module tb_btn_press_classifier;

    localparam int unsigned LONG   = 20;
    localparam int unsigned REPEAT = 5;

    logic clk;
    logic reset;

    btn_press_classifier_if bus ();

    btn_press_classifier #(
        .LONG_CYCLES   (LONG),
        .REPEAT_CYCLES (REPEAT)
    ) u_dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: sampled level, length of the current run of
    // sampled 1s, and length of a run that ended on the latest sample.
    bit m_btn_r = 1'b0;
    int m_run   = 0;
    int m_ended = 0;
    logic [2:0] exp_out;   // {short, long, held}
    logic [2:0] obs;

    function automatic bit long_point(input int run);
        if (run == LONG + 1) return 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
        if (run > LONG + 1 && ((run - LONG - 1) % REPEAT) == 0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    task automatic model_edge(input logic rst, input logic btn);
        if (rst) begin
            exp_out = 3'b000;
            m_btn_r = 1'b0;
            m_run   = 0;
            m_ended = 0;
        end else begin
            exp_out[2] = (m_ended >= 1) && (m_ended <= LONG);
            exp_out[1] = m_btn_r && long_point(m_run);
            exp_out[0] = m_btn_r && (m_run >= LONG + 1);
            if (btn) begin
                m_run   = m_btn_r ? m_run + 1 : 1;
                m_ended = 0;
            end else begin
                m_ended = m_btn_r ? m_run : 0;
                m_run   = 0;
            end
            m_btn_r = btn;
        end
    endtask

    task automatic check_int(input string name, input int got, input int req);
        n_checks++;
        if (got != req) begin
            n_errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    // One clock: drive inputs, take the edge, update the model, sample 1 ns later.
    task automatic step(input logic btn, input logic rst);
        bus.i_btn = btn;
        reset     = rst;
        @(posedge clk);
        model_edge(rst, btn);
        #1;
        obs = {bus.o_short, bus.o_long, bus.o_held};
        n_checks++;
        if (obs !== exp_out) begin
            n_errors++;
            $display("FAIL cycle_model @%0t: got short/long/held=%b, required %b",
                     $time, obs, exp_out);
        end
    endtask

    typedef struct {
        int n;          // consecutive 1 samples
        int shorts;     // expected o_short pulses
        int longs;      // expected o_long pulses
        int first_d;    // edges after the first 1 sample to the first pulse
        int held_cyc;   // cycles with o_held high
    } vec_t;

    vec_t vecs[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_s, n_l, first, held, first_s, second_s, first_l;

        vecs[0] = '{n: 1,  shorts: 1, longs: 0, first_d: 2,  held_cyc: 0};
        vecs[1] = '{n: 2,  shorts: 1, longs: 0, first_d: 3,  held_cyc: 0};
        vecs[2] = '{n: 5,  shorts: 1, longs: 0, first_d: 6,  held_cyc: 0};
        vecs[3] = '{n: 20, shorts: 1, longs: 0, first_d: 21, held_cyc: 0};
        vecs[4] = '{n: 21, shorts: 0, longs: 1, first_d: 21, held_cyc: 1};
`ifdef BTN_AUTO_REPEAT_EN
        vecs[5] = '{n: 40, shorts: 0, longs: 4, first_d: 21, held_cyc: 20};
`else
        vecs[5] = '{n: 40, shorts: 0, longs: 1, first_d: 21, held_cyc: 20};
`endif

        // Reset, then 50 quiet cycles.
        bus.i_btn = 1'b0;
        reset     = 1'b1;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        n_s = 0; n_l = 0; held = 0;
        for (int i = 0; i < 50; i++) begin
            step(1'b0, 1'b0);
            n_s += int'(obs[2]); n_l += int'(obs[1]); held += int'(obs[0]);
        end
        check_int("idle_pulses", n_s + n_l + held, 0);

        // Table-driven single presses.
        foreach (vecs[v]) begin
            n_s = 0; n_l = 0; held = 0; first = -1;
            for (int i = 0; i < vecs[v].n + 5; i++) begin
                step(i < vecs[v].n, 1'b0);
                n_s += int'(obs[2]); n_l += int'(obs[1]); held += int'(obs[0]);
                if (first < 0 && (obs[2] || obs[1])) first = i;
            end
            check_int($sformatf("vec%0d_shorts", v), n_s, vecs[v].shorts);
            check_int($sformatf("vec%0d_longs", v), n_l, vecs[v].longs);
            check_int($sformatf("vec%0d_first", v), first, vecs[v].first_d);
            check_int($sformatf("vec%0d_held", v), held, vecs[v].held_cyc);
        end

        // Reset in the middle of a held press; button still pressed at release.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
        n_s = 0; n_l = 0; held = 0;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1);
            n_s += int'(obs[2]); n_l += int'(obs[1]); held += int'(obs[0]);
        end
        check_int("reset_mid_press_pulses", n_s + n_l + held, 0);
        first_l = -1; n_s = 0; n_l = 0;
        for (int i = 0; i < 30; i++) begin
            step(i < 25, 1'b0);
            n_s += int'(obs[2]); n_l += int'(obs[1]);
            if (first_l < 0 && obs[1]) first_l = i;
        end
        check_int("reset_repress_first_long", first_l, 21);
        check_int("reset_repress_longs", n_l, 1);
        check_int("reset_repress_shorts", n_s, 0);

        // Release and re-press with a one-cycle gap: 3 high, 1 low, 4 high.
        first_s = -1; second_s = -1; n_s = 0;
        for (int i = 0; i < 14; i++) begin
            step((i < 3) || (i >= 4 && i < 8), 1'b0);
            if (obs[2]) begin
                n_s++;
                if (first_s < 0) first_s = i;
                else second_s = i;
            end
        end
        check_int("gap_shorts", n_s, 2);
        check_int("gap_first_short", first_s, 4);
        check_int("gap_separation", second_s - first_s, 5);

        // Random presses of mixed lengths with occasional resets.
        for (int p = 0; p < 120; p++) begin
            int len, gap;
            len = ($urandom_range(0, 9) < 7) ? $urandom_range(1, 8) : $urandom_range(18, 45);
            gap = $urandom_range(1, 6);
            for (int i = 0; i < len + gap; i++) begin
                step(i < len, $urandom_range(0, 149) == 0);
            end
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/btn_press_classifier.md
# btn_press_classifier

Converts the debounced button level from the debounce stage into single-cycle press events for the stopwatch control FSM. Sits directly downstream of the debouncer: one instance per button. Distinguishes a short press (released before the long threshold) from a long press (held past it), and optionally emits auto-repeat events while held. All outputs are registered; the FSM never sees raw levels.

## Interface
- LONG_CYCLES, 100_000_000: clock cycles of continuous press that classify as long (1 s at 100 MHz); must be ≥ 2.
- REPEAT_CYCLES, 20_000_000: auto-repeat period in cycles while long-held; used only with the macro; must be ≥ 1.
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- i_btn  input  1  debounced button level (1 = pressed), from debounce o_btn.
- o_short  output  1  one-cycle pulse: press ended before long threshold.
- o_long  output  1  one-cycle pulse: long threshold reached (and each repeat, if enabled).
- o_held  output  1  level: button currently in long-held state.

## Operation
- Input register btn_r <= i_btn every edge; reset value 0. FSM acts on btn_r only.
- Press counter cnt, width $clog2(LONG_CYCLES+1); repeat counter rcnt, width $clog2(REPEAT_CYCLES+1) (macro builds only).
- States: IDLE, PRESSED, LONG_HELD.
- IDLE: btn_r=1 -> PRESSED, cnt<=1. Else stay.
- PRESSED: btn_r=0 -> IDLE, o_short<=1. btn_r=1 and cnt==LONG_CYCLES -> LONG_HELD, o_long<=1, rcnt<=0. Otherwise cnt<=cnt+1 (never exceeds LONG_CYCLES).
- LONG_HELD: btn_r=0 -> IDLE, no pulse (release after long press is silent). btn_r=1 -> stay; repeat handling per Configuration.
- o_short, o_long default 0 every cycle unless set above; never both 1 in the same cycle.
- o_held registered: 1 exactly while state==LONG_HELD.
- Reset (any state, any cycle): state IDLE, cnt=0, rcnt=0, btn_r=0, all outputs 0; no pulse generated by reset or its release. Button still pressed at reset release is treated as a fresh press.

## Timing
- Let edge k be the first edge sampling i_btn=1, and N the number of consecutive edges sampling 1.
- N ≤ LONG_CYCLES: o_short high during the cycle after edge k+N+1; no o_long.
- N ≥ LONG_CYCLES+1: o_long high during the cycle after edge k+LONG_CYCLES+1; o_held rises on the same edge; o_held falls on edge k+N+1.
- N = 1 (single-cycle glitch passing the debouncer) still yields o_short.
- Re-press in the cycle immediately after the release pulse is accepted (IDLE -> PRESSED on the next edge); no dead time.

## Configuration
- Macro BTN_AUTO_REPEAT_EN.
- Defined: in LONG_HELD with btn_r=1, rcnt increments each cycle; when rcnt==REPEAT_CYCLES-1, o_long<=1 and rcnt<=0. Repeat pulses therefore occur every REPEAT_CYCLES cycles after the first o_long, until release. Release resets rcnt to 0.
- Not defined: rcnt and its logic absent; exactly one o_long per press regardless of hold length.

## Test plan
- Parameters for bench: LONG_CYCLES=20, REPEAT_CYCLES=5, 10 ns clock.
- Reset 1 for 2 cycles, i_btn=0 -> all outputs 0, no pulses for 50 cycles.
- i_btn=1 for 5 cycles then 0 -> exactly one o_short, 7 cycles after first high sample; o_long, o_held stay 0.
- i_btn=1 for exactly 20 cycles, then for exactly 21 cycles (separate presses) -> first gives o_short only; second gives o_long at cycle 22, o_held 1 until 1 cycle after release, no o_short.
- i_btn=1 for 40 cycles, macro defined -> o_long at cycles 22, 27, 32, 37 (4 pulses); macro undefined -> single pulse at 22.
- Reset asserted at cycle 10 of a held press, released at cycle 12 with i_btn still 1, held 25 more cycles -> no pulse at reset; o_long at 22 cycles after release-edge sampling, none before.
- Release and re-press with 1-cycle gap -> two o_short pulses, separated by gap+press length, no merged or lost event.
